// File: rtl/qspi_port_arbiter.sv
// Round-robin arbiter sharing one QSPI controller between instruction fetch (port 0) and CPU data (port 1).
// Optional watchdog enabled by defining QSPI_ARB_TIMEOUT_EN.
module qspi_port_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ack,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ack,
    output logic              mem_start,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy,
    output logic              arb_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RISE,
        S_WAIT_FALL,
        S_ACK
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_last_grant;
    logic                r_grant_id;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_p0_rdata;
    logic [DATA_W-1:0]   r_p1_rdata;
    logic                w_grant_sel;
    logic                w_capture;
    logic                w_to_fire;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_cap_data;

    // On a tie the port that did not win last time is served.
    assign w_grant_sel = (p0_req && p1_req) ? ~r_last_grant : p1_req;
    assign w_cap_data  = w_to_fire ? '1 : mem_rdata;

    always_comb begin
        w_next    = r_state;
        mem_start = 1'b0;
        p0_ack    = 1'b0;
        p1_ack    = 1'b0;
        w_capture = 1'b0;
        w_to_fire = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (p0_req || p1_req) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (!mem_busy) begin
                    mem_start = 1'b1;
                    w_next    = S_WAIT_RISE;
                end else if (w_timeout) begin
                    w_capture = 1'b1;
                    w_to_fire = 1'b1;
                    w_next    = S_ACK;
                end
            end
            S_WAIT_RISE: begin
                if (mem_busy) begin
                    w_next = S_WAIT_FALL;
                end else if (w_timeout) begin
                    w_capture = 1'b1;
                    w_to_fire = 1'b1;
                    w_next    = S_ACK;
                end
            end
            S_WAIT_FALL: begin
                if (!mem_busy) begin
                    w_capture = 1'b1;
                    w_next    = S_ACK;
                end else if (w_timeout) begin
                    w_capture = 1'b1;
                    w_to_fire = 1'b1;
                    w_next    = S_ACK;
                end
            end
            S_ACK: begin
                p0_ack = ~r_grant_id;
                p1_ack = r_grant_id;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && (p0_req || p1_req)) begin
                r_grant_id   <= w_grant_sel;
                r_last_grant <= w_grant_sel;
                r_mem_write  <= w_grant_sel & p1_we;
                r_mem_addr   <= w_grant_sel ? p1_addr : p0_addr;
                r_mem_wdata  <= w_grant_sel ? p1_wdata : '0;
            end
            if (w_capture) begin
                if (r_grant_id) r_p1_rdata <= w_cap_data;
                else            r_p0_rdata <= w_cap_data;
            end
        end
    end

`ifdef QSPI_ARB_TIMEOUT_EN
    localparam logic [9:0] WDOG_LIMIT = 10'(TIMEOUT_CYC);

    logic [9:0] r_wdog;
    logic       r_arb_err;
    logic       w_in_txn;

    assign w_in_txn  = (r_state == S_ISSUE) || (r_state == S_WAIT_RISE) || (r_state == S_WAIT_FALL);
    assign w_timeout = w_in_txn && (r_wdog == WDOG_LIMIT);
    assign arb_err   = r_arb_err;

    // Counter is held at zero in IDLE so it starts from zero on entry to ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog    <= '0;
            r_arb_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE) r_wdog <= '0;
            else if (w_in_txn)     r_wdog <= r_wdog + 10'd1;
            if (w_to_fire)         r_arb_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign arb_err   = 1'b0;
`endif

    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;

endmodule

// File: tb/tb_qspi_port_arbiter.sv
// Bench for qspi_port_arbiter: controller model, transaction logs and a round-robin reference model.
module tb_qspi_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p1_req, p1_we;
    logic [23:0] p0_addr, p1_addr, mem_addr;
    logic [7:0]  p0_rdata, p1_rdata, p1_wdata, mem_wdata, mem_rdata;
    logic        p0_ack, p1_ack, mem_start, mem_write, mem_busy, arb_err;

    always #5 clk = ~clk;

    qspi_port_arbiter #(.ADDR_W(24), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .mem_start(mem_start), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy), .arb_err(arb_err)
    );

    typedef struct packed { logic w; logic [23:0] a; logic [7:0] wd; logic [7:0] rd; } st_t;
    typedef struct packed { logic both; logic port; logic [7:0] rd; } ak_t;

    st_t  start_q[$];
    ak_t  ack_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   m_last;
    int   ctl_lat = 1;
    logic force_busy = 1'b0;
    logic fix_rd_en = 1'b0;
    logic [7:0] fix_rd = 8'h00;
    logic st_seen = 1'b0;
    logic [7:0] st_rd = 8'h00;
    int   cnt;

    // Controller model: busy for ctl_lat cycles after each start, read data chosen at start.
    assign mem_busy = force_busy | (cnt != 0);
    initial mem_rdata = 8'h00;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 0;
        else if (st_seen) begin
            cnt       <= ctl_lat;
            mem_rdata <= st_rd;
        end else if (cnt != 0) cnt <= cnt - 1;
    end

    always @(negedge clk) begin
        st_seen = mem_start;
        if (mem_start) begin
            st_rd = fix_rd_en ? fix_rd : 8'($urandom);
            start_q.push_back('{mem_write, mem_addr, mem_wdata, st_rd});
        end
        if (p0_ack || p1_ack) ack_q.push_back('{p0_ack & p1_ack, p1_ack, p1_ack ? p1_rdata : p0_rdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, 32'(mem_start), 0);
        chk({tag, "_write"}, 32'(mem_write), 0);
        chk({tag, "_addr"},  32'(mem_addr), 0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_acks"},  32'({p0_ack, p1_ack}), 0);
        chk({tag, "_rdata"}, 32'({p0_rdata, p1_rdata}), 0);
        chk({tag, "_err"},   32'(arb_err), 0);
    endtask

    task automatic run_round(input bit r0, input bit r1, input logic [23:0] a0, input logic [23:0] a1,
                             input bit we, input logic [7:0] wd, input int lat, output int first_lat);
        bit  ord[$];
        int  sb, ab, c;
        st_t s;
        ak_t k;
        bit  exp_w;
        sb = start_q.size();
        ab = ack_q.size();
        if (r0 && r1) begin
            ord.push_back(!m_last);
            ord.push_back(m_last);
        end else ord.push_back(r1);
        m_last    = ord[ord.size()-1];
        ctl_lat   = lat;
        first_lat = -1;
        @(negedge clk);
        p0_req = r0; p0_addr = a0;
        p1_req = r1; p1_addr = a1; p1_we = we; p1_wdata = wd;
        c = 0;
        while ((p0_req || p1_req) && c < 400) begin
            @(negedge clk);
            c++;
            if ((p0_ack || p1_ack) && first_lat < 0) first_lat = c;
            if (p0_ack) p0_req = 1'b0;
            if (p1_ack) p1_req = 1'b0;
        end
        chk("round_done", 32'({p0_req, p1_req}), 0);
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk);
        chk("start_count", 32'(start_q.size() - sb), 32'(ord.size()));
        chk("ack_count", 32'(ack_q.size() - ab), 32'(ord.size()));
        for (int i = 0; i < ord.size(); i++) begin
            if (sb + i < start_q.size() && ab + i < ack_q.size()) begin
                s = start_q[sb+i];
                k = ack_q[ab+i];
                exp_w = ord[i] ? we : 1'b0;
                chk("ack_overlap", 32'(k.both), 0);
                chk("grant_port", 32'(k.port), 32'(ord[i]));
                chk("mem_write", 32'(s.w), 32'(exp_w));
                chk("mem_addr", 32'(s.a), 32'(ord[i] ? a1 : a0));
                if (exp_w) chk("mem_wdata", 32'(s.wd), 32'(wd));
                else       chk("rdata", 32'(k.rd), 32'(s.rd));
            end
        end
    endtask

    initial begin
        int lat, c, sb, ab;
        bit exp_port;
        rst_n = 1'b0;
        p0_req = 0; p1_req = 0; p1_we = 0; p0_addr = 0; p1_addr = 0; p1_wdata = 0;
        m_last = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Port 0 read, fixed controller data
        fix_rd_en = 1'b1; fix_rd = 8'hA5;
        run_round(1, 0, 24'h000100, 24'h0, 0, 8'h00, 6, lat);
        chk("p0_latency", 32'(lat), 32'(6 + 3));
        chk("p0_rdata_a5", 32'(p0_rdata), 32'h000000A5);

        // Port 1 write
        run_round(0, 1, 24'h0, 24'h000200, 1, 8'h3C, 4, lat);
        chk("p0_rdata_hold", 32'(p0_rdata), 32'h000000A5);
        fix_rd_en = 1'b0;

        // Both ports requesting continuously for 4 transactions
        sb = start_q.size(); ab = ack_q.size();
        ctl_lat = 3;
        @(negedge clk);
        p0_req = 1; p0_addr = 24'h000400; p1_req = 1; p1_we = 0; p1_addr = 24'h000500;
        c = 0;
        while (ack_q.size() - ab < 4 && c < 200) begin
            @(negedge clk);
            c++;
        end
        p0_req = 0; p1_req = 0;
        repeat (3) @(negedge clk);
        chk("cont_acks", 32'(ack_q.size() - ab), 4);
        chk("cont_starts", 32'(start_q.size() - sb), 4);
        for (int i = 0; i < 4; i++) begin
            if (ab + i < ack_q.size()) begin
                exp_port = !m_last;
                m_last   = exp_port;
                chk("cont_port", 32'(ack_q[ab+i].port), 32'(exp_port));
                chk("cont_overlap", 32'(ack_q[ab+i].both), 0);
            end
        end

        // Controller still busy at grant
        sb = start_q.size(); ab = ack_q.size();
        force_busy = 1'b1; ctl_lat = 2;
        @(negedge clk);
        p0_req = 1; p0_addr = 24'h000300;
        repeat (10) @(negedge clk);
        chk("busy_no_start", 32'(start_q.size() - sb), 0);
        chk("busy_no_ack", 32'(ack_q.size() - ab), 0);
        force_busy = 1'b0;
        c = 0;
        while (!p0_ack && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("busy_ack", 32'(p0_ack), 1);
        p0_req = 0;
        m_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_one_start", 32'(start_q.size() - sb), 1);

        // Randomized rounds against the round-robin model
        for (int r = 0; r < 24; r++) begin
            int m;
            m = $urandom_range(1, 3);
            run_round(m[0], m[1], 24'($urandom), 24'($urandom), 1'($urandom), 8'($urandom),
                      $urandom_range(1, 5), lat);
        end

        // Reset while waiting for busy to fall
        ctl_lat = 20;
        @(negedge clk);
        p0_req = 1; p0_addr = 24'h000600;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        p0_req = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_last = 1'b1;
        run_round(1, 1, 24'h000700, 24'h000800, 0, 8'h00, 3, lat);

`ifdef QSPI_ARB_TIMEOUT_EN
        force_busy = 1'b1;
        @(negedge clk);
        p1_req = 1; p1_we = 0; p1_addr = 24'h000900;
        c = 0;
        while (!p1_ack && c < 60) begin
            @(negedge clk);
            c++;
        end
        chk("to_ack", 32'(p1_ack), 1);
        chk("to_window", 32'(c >= 16 && c <= 20), 1);
        chk("to_rdata", 32'(p1_rdata), 32'h000000FF);
        chk("to_err", 32'(arb_err), 1);
        p1_req = 0;
        m_last = 1'b1;
        @(negedge clk);
        force_busy = 1'b0;
        run_round(1, 0, 24'h000A00, 24'h0, 0, 8'h00, 2, lat);
        chk("to_err_sticky", 32'(arb_err), 1);
`else
        chk("err_tied_low", 32'(arb_err), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
